audio_sample_streamer: RTL and testbench



---
 rtl/audio_sample_streamer.sv | 215 +++++++++++++++++++++
 tb/tb_audio_sample_streamer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_streamer.sv
// audio_sample_streamer: Avalon-MM register slave feeding a stereo FIFO that is
// unpacked into left/right Avalon-ST sample streams for the audio DAC core.
//
// Pop/output state machine
//   state    | meaning
//   ST_IDLE  | no pair is being served; when enable=1, the FIFO is not empty and
//            | both valids are low, the LOAD step runs: one word is popped and
//            | both holding registers load on that same edge
//   ST_SERVE | holding registers are presented; each channel drops its own valid
//            | on valid&ready, and the machine returns to IDLE once both are low
module audio_sample_streamer #(
  parameter int DEPTH_LOG2 = 8,   // 4..10
  parameter int SAMPLE_W   = 16   // <= 16
) (
  input  logic                clk_sys,
  input  logic                rst_b,
  input  logic [1:0]          avs_address,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  input  logic                avs_read,
  output logic [31:0]         avs_readdata,
  output logic [SAMPLE_W-1:0] left_data,
  output logic [SAMPLE_W-1:0] right_data,
  output logic                left_valid,
  output logic                right_valid,
  input  logic                left_ready,
  input  logic                right_ready,
  output logic                irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam int WORD_W = 2 * SAMPLE_W;
  localparam logic [LVL_W-1:0]      LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]      LVL_ONE  = LVL_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_THRESH = 2'd3;

  typedef enum logic [0:0] {ST_IDLE, ST_SERVE} state_t;

  state_t                 state_q;
  logic                   enable_q, irq_en_q;
  logic [LVL_W-1:0]       thresh_q;
  logic [LVL_W-1:0]       level_q;
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
  logic                   ovf_q, udr_q, primed_q;
  logic                   left_valid_q, right_valid_q;
  logic [SAMPLE_W-1:0]    left_data_q, right_data_q;
  logic                   irq_q;
  logic [31:0]            readdata_q;
  logic [WORD_W-1:0]      mem [DEPTH];

  logic              wr_data, wr_status, wr_ctrl, wr_thresh;
  logic              flush, full, empty;
  logic              push_ok, ovf_set, pop, udr_set;
  logic [WORD_W-1:0] push_word, pop_word;
  logic [31:0]       readdata_d;

  assign wr_data   = avs_write && (avs_address == A_DATA);
  assign wr_status = avs_write && (avs_address == A_STATUS);
  assign wr_ctrl   = avs_write && (avs_address == A_CTRL);
  assign wr_thresh = avs_write && (avs_address == A_THRESH);

  // Flush outranks a same-cycle DATA write: the word is discarded silently.
  assign flush = wr_ctrl && avs_writedata[2];

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);

  // Fullness is judged on the pre-cycle level, so a same-cycle pop never rescues a push.
  assign push_ok = wr_data && !full && !flush;
  assign ovf_set = wr_data &&  full && !flush;

  assign pop = (state_q == ST_IDLE) && enable_q && !empty &&
               !left_valid_q && !right_valid_q && !flush;

  assign udr_set = primed_q && enable_q && empty && (left_ready || right_ready) &&
                   !left_valid_q && !right_valid_q;

  assign push_word = {avs_writedata[16 +: SAMPLE_W], avs_writedata[0 +: SAMPLE_W]};
  assign pop_word  = mem[rd_ptr_q];

  // Control and threshold registers; the flush bit is a strobe and is never stored.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      thresh_q <= '0;
    end else begin
      if (wr_ctrl) begin
        enable_q <= avs_writedata[0];
        irq_en_q <= avs_writedata[1];
      end
      if (wr_thresh) thresh_q <= avs_writedata[LVL_W-1:0];
    end
  end

  // Sample storage; contents need no reset because level gates every read.
  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wr_ptr_q] <= push_word;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky error flags (set beats a same-cycle W1C) and the underrun arming flag.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      ovf_q    <= 1'b0;
      udr_q    <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set || (ovf_q && !(wr_status && avs_writedata[18]));
      udr_q <= udr_set || (udr_q && !(wr_status && avs_writedata[19]));
      if (!enable_q || flush) primed_q <= 1'b0;
      else if (pop)           primed_q <= 1'b1;
    end
  end

  // Pop/output state machine with registered holding registers and valids.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= ST_IDLE;
      left_valid_q  <= 1'b0;
      right_valid_q <= 1'b0;
      left_data_q   <= '0;
      right_data_q  <= '0;
    end else if (flush) begin
      state_q       <= ST_IDLE;
      left_valid_q  <= 1'b0;
      right_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            left_data_q   <= pop_word[WORD_W-1:SAMPLE_W];
            right_data_q  <= pop_word[SAMPLE_W-1:0];
            left_valid_q  <= 1'b1;
            right_valid_q <= 1'b1;
            state_q       <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          left_valid_q  <= left_valid_q  && !left_ready;
          right_valid_q <= right_valid_q && !right_ready;
          if (!(left_valid_q && !left_ready) && !(right_valid_q && !right_ready))
            state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Read-data mux for the register map.
  always_comb begin
    readdata_d = '0;
    case (avs_address)
      A_STATUS: begin
        readdata_d[LVL_W-1:0] = level_q;
        readdata_d[16]        = empty;
        readdata_d[17]        = full;
        readdata_d[18]        = ovf_q;
        readdata_d[19]        = udr_q;
        readdata_d[20]        = irq_q;
      end
      A_CTRL: begin
        readdata_d[0] = enable_q;
        readdata_d[1] = irq_en_q;
      end
      A_THRESH: readdata_d[LVL_W-1:0] = thresh_q;
      default:  readdata_d = '0;
    endcase
  end

  // Registered read data and low-water interrupt.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (avs_read) readdata_q <= readdata_d;
      irq_q <= enable_q && irq_en_q && (level_q <= thresh_q);
    end
  end

  assign avs_readdata = readdata_q;
  assign left_data    = left_data_q;
  assign right_data   = right_data_q;
  assign left_valid   = left_valid_q;
  assign right_valid  = right_valid_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Bench for audio_sample_streamer: directed register/stream scenarios plus a
// randomized traffic phase, checked against a FIFO/scoreboard model.
module tb_audio_sample_streamer;
  localparam int DL    = 4;
  localparam int SW    = 16;
  localparam int DEPTH = 1 << DL;

  logic          clk_sys = 1'b0;
  logic          rst_b   = 1'b0;
  logic [1:0]    avs_address = '0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic          avs_read = 1'b0;
  logic [31:0]   avs_readdata;
  logic [SW-1:0] left_data, right_data;
  logic          left_valid, right_valid;
  logic          left_ready = 1'b0;
  logic          right_ready = 1'b0;
  logic          irq;

  audio_sample_streamer #(.DEPTH_LOG2(DL), .SAMPLE_W(SW)) dut (
    .clk_sys       (clk_sys),
    .rst_b         (rst_b),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .left_data     (left_data),
    .right_data    (right_data),
    .left_valid    (left_valid),
    .right_valid   (right_valid),
    .left_ready    (left_ready),
    .right_ready   (right_ready),
    .irq           (irq)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] lq[$];
  logic [15:0] rq[$];
  int   mdl_level  = 0;
  bit   mdl_en     = 0;
  bit   mdl_irq_en = 0;
  int   mdl_thresh = 0;
  int   lc = 0;
  int   rc = 0;
  logic prev_lv = 1'b0;
  logic exp_irq = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    tick();
    avs_write = 1'b0;
    case (addr)
      2'd0: if (mdl_level < DEPTH) begin
        mdl_level++;
        lq.push_back(data[31:16]);
        rq.push_back(data[15:0]);
      end
      2'd2: begin
        mdl_en     = data[0];
        mdl_irq_en = data[1];
        if (data[2]) begin
          mdl_level = 0;
          lq.delete();
          rq.delete();
        end
      end
      2'd3: mdl_thresh = int'(data[DL:0]);
      default: ;
    endcase
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    avs_address = addr;
    avs_read    = 1'b1;
    tick();
    avs_read = 1'b0;
    data = avs_readdata;
  endtask

  // Stream scoreboard, pop tracking and interrupt model, sampled mid-cycle.
  always @(negedge clk_sys) begin
    if (!rst_b) begin
      prev_lv = 1'b0;
      exp_irq = 1'b0;
    end else begin
      if (left_valid && left_ready) begin
        if (lq.size() == 0) check("left_extra_sample", 32'(lq.size()), 32'd1);
        else check("left_data", {16'd0, left_data}, {16'd0, lq.pop_front()});
        lc++;
        check("lr_skew", 32'((lc - rc <= 1) && (rc - lc <= 1)), 32'd1);
      end
      if (right_valid && right_ready) begin
        if (rq.size() == 0) check("right_extra_sample", 32'(rq.size()), 32'd1);
        else check("right_data", {16'd0, right_data}, {16'd0, rq.pop_front()});
        rc++;
        check("lr_skew", 32'((lc - rc <= 1) && (rc - lc <= 1)), 32'd1);
      end
      if (left_valid && !prev_lv) mdl_level--;
      prev_lv = left_valid;
      check("irq", {31'd0, irq}, {31'd0, exp_irq});
      exp_irq = mdl_en && mdl_irq_en && (mdl_level <= mdl_thresh);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lc0, rc0;

    // Reset state
    repeat (3) tick();
    check("rst_left_valid",  {31'd0, left_valid},  32'd0);
    check("rst_right_valid", {31'd0, right_valid}, 32'd0);
    check("rst_irq",         {31'd0, irq},         32'd0);
    check("rst_readdata",    avs_readdata,         32'd0);
    check("rst_left_data",   {16'd0, left_data},   32'd0);
    rst_b = 1'b1;
    tick();
    bus_read(2'd1, rd); check("rst_status",  rd, 32'h0001_0000);
    bus_read(2'd2, rd); check("rst_control", rd, 32'h0000_0000);

    // First sample latency
    left_ready = 1'b1; right_ready = 1'b1;
    bus_write(2'd2, 32'h1);
    bus_write(2'd0, 32'h1234_ABCD);
    check("first_valid_c1", {31'd0, left_valid}, 32'd0);
    tick();
    check("first_lvalid_c2", {31'd0, left_valid},  32'd1);
    check("first_rvalid_c2", {31'd0, right_valid}, 32'd1);
    check("first_ldata",     {16'd0, left_data},   32'h0000_1234);
    check("first_rdata",     {16'd0, right_data},  32'h0000_ABCD);
    tick();
    check("first_lvalid_c3", {31'd0, left_valid},  32'd0);
    check("first_rvalid_c3", {31'd0, right_valid}, 32'd0);

    // Overflow with a stopped stream, W1C, then random-ready drain
    bus_write(2'd2, 32'h0);
    repeat (17) bus_write(2'd0, $urandom);
    bus_read(2'd1, rd); check("ovf_status", rd, 32'h000E_0010);
    bus_write(2'd1, 32'h000C_0000);
    bus_read(2'd1, rd); check("ovf_cleared", rd, 32'h0002_0010);
    bus_write(2'd2, 32'h1);
    for (int i = 0; i < 1000 && (lq.size() != 0 || rq.size() != 0); i++) begin
      left_ready  = 1'($urandom_range(0, 1));
      right_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("ovf_drain_left_done",  32'(lq.size()), 32'd0);
    check("ovf_drain_right_done", 32'(rq.size()), 32'd0);
    left_ready = 1'b1; right_ready = 1'b1;
    repeat (10) tick();
    check("no_17th_word", {31'd0, left_valid}, 32'd0);

    // Right channel stalled: only one pair leaves, alignment kept
    bus_write(2'd2, 32'h0);
    left_ready = 1'b1; right_ready = 1'b0;
    repeat (3) bus_write(2'd0, $urandom);
    lc0 = lc; rc0 = rc;
    bus_write(2'd2, 32'h1);
    repeat (10) tick();
    check("stall_left_pops",  32'(lc - lc0), 32'd1);
    check("stall_right_pops", 32'(rc - rc0), 32'd0);
    bus_read(2'd1, rd); check("stall_level", rd & 32'h1F, 32'd2);
    right_ready = 1'b1;
    for (int i = 0; i < 100 && (lq.size() != 0 || rq.size() != 0); i++) tick();
    check("stall_left_total",  32'(lc - lc0), 32'd3);
    check("stall_right_total", 32'(rc - rc0), 32'd3);

    // Randomized traffic with overflow possible and the irq model active
    bus_write(2'd3, 32'($urandom_range(0, DEPTH)));
    bus_write(2'd2, 32'h3);
    for (int i = 0; i < 400; i++) begin
      left_ready  = ($urandom_range(0, 3) != 0);
      right_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) bus_write(2'd0, $urandom);
      else tick();
    end
    left_ready = 1'b1; right_ready = 1'b1;
    for (int i = 0; i < 200 && (lq.size() != 0 || rq.size() != 0); i++) tick();
    check("rand_drain_done", 32'(lq.size() + rq.size()), 32'd0);

    // Low-water interrupt around THRESH=2
    left_ready = 1'b0; right_ready = 1'b0;
    bus_write(2'd2, 32'h2);
    bus_write(2'd3, 32'h2);
    repeat (5) bus_write(2'd0, $urandom);
    bus_write(2'd2, 32'h3);
    left_ready = 1'b1; right_ready = 1'b1;
    for (int i = 0; i < 200 && mdl_level > 2; i++) tick();
    left_ready = 1'b0; right_ready = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 4 && mdl_level < 2; i++) bus_write(2'd0, $urandom);
    tick();
    check("irq_at_level2", {31'd0, irq}, 32'd1);
    bus_write(2'd0, $urandom);
    check("irq_hold_after_write", {31'd0, irq}, 32'd1);
    tick();
    check("irq_fall_level3", {31'd0, irq}, 32'd0);
    left_ready = 1'b1; right_ready = 1'b1;
    for (int i = 0; i < 200 && (lq.size() != 0 || rq.size() != 0); i++) tick();
    check("irq_drain_done", 32'(lq.size() + rq.size()), 32'd0);

    // Underrun, then flush keeps the sticky bit
    bus_write(2'd2, 32'h0);
    repeat (2) tick();
    bus_write(2'd1, 32'h000C_0000);
    bus_read(2'd1, rd); check("udr_cleared", rd, 32'h0001_0000);
    bus_write(2'd2, 32'h1);
    bus_read(2'd1, rd); check("udr_not_primed", rd, 32'h0001_0000);
    bus_write(2'd0, $urandom);
    repeat (8) tick();
    bus_read(2'd1, rd); check("udr_set", rd, 32'h0009_0000);
    left_ready = 1'b0; right_ready = 1'b0;
    repeat (3) bus_write(2'd0, $urandom);
    repeat (3) tick();
    check("pre_flush_valid", {31'd0, left_valid}, 32'd1);
    bus_write(2'd2, 32'h5);
    check("flush_lvalid", {31'd0, left_valid},  32'd0);
    check("flush_rvalid", {31'd0, right_valid}, 32'd0);
    bus_read(2'd1, rd); check("flush_status",  rd, 32'h0009_0000);
    bus_read(2'd2, rd); check("flush_control", rd, 32'h0000_0001);

    // Asynchronous reset mid-operation
    repeat (3) bus_write(2'd0, $urandom);
    repeat (3) tick();
    rst_b = 1'b0;
    lq.delete(); rq.delete();
    mdl_level = 0; mdl_en = 0; mdl_irq_en = 0; mdl_thresh = 0;
    #2;
    check("arst_lvalid",   {31'd0, left_valid},  32'd0);
    check("arst_rvalid",   {31'd0, right_valid}, 32'd0);
    check("arst_readdata", avs_readdata,         32'd0);
    repeat (2) tick();
    rst_b = 1'b1;
    tick();
    bus_read(2'd1, rd); check("arst_status",  rd, 32'h0001_0000);
    bus_read(2'd3, rd); check("arst_thresh",  rd, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
